// File: rtl/ex_operand_stage_if.sv
// ID-to-EX instruction bundle for the operand stage.
// The ID side drives it; the EX operand stage consumes it.
interface ex_operand_stage_if;
    logic        id_valid;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [3:0]  id_ALU_control;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;

    modport master (
        output id_valid, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_ALU_control, id_alu_src,
        output id_reg_write, id_mem_read, id_mem_write, id_branch
    );

    modport slave (
        input id_valid, id_rs1_data, id_rs2_data, id_imm,
        input id_rs1_addr, id_rs2_addr, id_rd_addr,
        input id_ALU_control, id_alu_src,
        input id_reg_write, id_mem_read, id_mem_write, id_branch
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Operands are pass-through only; no arithmetic lives here.
module ex_operand_stage (
    input  logic                     clk,
    input  logic                     rst_n,
    ex_operand_stage_if.slave        id_bus,
    input  logic                     exmem_reg_write,
    input  logic [4:0]               exmem_rd,
    input  logic [31:0]              exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [4:0]               memwb_rd,
    input  logic [31:0]              memwb_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic [31:0]              A,
    output logic [31:0]              B,
    output logic [3:0]               ALU_control,
    output logic [31:0]              store_data,
    output logic [4:0]               ex_rd,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_branch,
    output logic                     load_use_hazard
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } ex_regs_t;

    localparam ex_regs_t BUBBLE = '0;

    ex_regs_t r;
    ex_regs_t id_in;

    logic [31:0] fwd1;
    logic [31:0] fwd2;

    always_comb begin
        id_in           = BUBBLE;
        id_in.valid     = id_bus.id_valid;
        id_in.rs1_data  = id_bus.id_rs1_data;
        id_in.rs2_data  = id_bus.id_rs2_data;
        id_in.imm       = id_bus.id_imm;
        id_in.rs1_addr  = id_bus.id_rs1_addr;
        id_in.rs2_addr  = id_bus.id_rs2_addr;
        id_in.rd        = id_bus.id_rd_addr;
        id_in.alu_ctrl  = id_bus.id_ALU_control;
        id_in.alu_src   = id_bus.id_alu_src;
        id_in.reg_write = id_bus.id_reg_write;
        id_in.mem_read  = id_bus.id_mem_read;
        id_in.mem_write = id_bus.id_mem_write;
        id_in.branch    = id_bus.id_branch;
    end

    // A load in EX whose rd feeds the instruction in ID cannot be forwarded in time.
    always_comb begin
        load_use_hazard = r.valid & r.mem_read & (r.rd != 5'd0)
                        & id_bus.id_valid
                        & ((r.rd == id_bus.id_rs1_addr) |
                           (r.rd == id_bus.id_rs2_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= BUBBLE;
        end else begin
            priority case (1'b1)
                flush:           r <= BUBBLE;
                stall:           r <= r;
                load_use_hazard: r <= BUBBLE;
                default:         r <= id_in;
            endcase
        end
    end

    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  addr,
        input logic [31:0] reg_data,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_res,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_dat
    );
        logic [31:0] res;
        res = reg_data;
        if (em_we && (em_rd != 5'd0) && (em_rd == addr))
            res = em_res;
        else if (mw_we && (mw_rd != 5'd0) && (mw_rd == addr))
            res = mw_dat;
        return res;
    endfunction

    always_comb begin
        fwd1 = fwd_sel(r.rs1_addr, r.rs1_data,
                       exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
        fwd2 = fwd_sel(r.rs2_addr, r.rs2_data,
                       exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
    end

    always_comb begin
        A          = fwd1;
        B          = r.alu_src ? r.imm : fwd2;
        store_data = fwd2;
    end

    assign ALU_control  = r.alu_ctrl;
    assign ex_rd        = r.rd;
    assign ex_valid     = r.valid;
    assign ex_reg_write = r.reg_write;
    assign ex_mem_read  = r.mem_read;
    assign ex_mem_write = r.mem_write;
    assign ex_branch    = r.branch;

endmodule
